// File: rtl/cam_match_encoder.sv
// CAM match-line post-processor: keeps the per-entry valid vector, gates raw
// match lines with it and encodes the lowest hit index, hit count and
// multi-hit flag through a two-stage valid/ready pipeline.
module cam_match_encoder #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = (1 << ADDR_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  // search request from the CAM array
  input  logic                  match_valid_i,
  input  logic [DEPTH-1:0]      match_i,
  output logic                  match_ready_o,
  // valid-bit maintenance
  input  logic                  set_valid_i,
  input  logic [ADDR_WIDTH-1:0] set_index_i,
  input  logic                  clear_valid_i,
  input  logic [ADDR_WIDTH-1:0] clear_index_i,
  input  logic                  clear_all_i,
  output logic [DEPTH-1:0]      valid_bits_o,
  // search result
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  hit_o,
  output logic [ADDR_WIDTH-1:0] index_o,
  output logic [ADDR_WIDTH:0]   hit_count_o,
  output logic                  multi_hit_o
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;

  // Entry valid vector
  logic [DEPTH-1:0]      valid_q, valid_d;

  // Stage 1: gated match vector
  logic                  s1_valid_q, s1_valid_d;
  logic [DEPTH-1:0]      s1_vec_q, s1_vec_d;

  // Stage 2: encoded result
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_hit_q, s2_hit_d;
  logic [ADDR_WIDTH-1:0] s2_index_q, s2_index_d;
  logic [CntW-1:0]       s2_count_q, s2_count_d;
  logic                  s2_multi_q, s2_multi_d;

  // Encoder outputs computed from S1
  logic                  enc_hit;
  logic [ADDR_WIDTH-1:0] enc_index;
  logic [CntW-1:0]       enc_count;

  logic                  s2_load;
  logic                  accept;

  // S2 can take a new entry when empty or when its result leaves this cycle.
  assign s2_load       = !s2_valid_q || result_ready_i;
  // S1 advances whenever S2 can load, so S1 has room if empty or advancing.
  assign match_ready_o = !s1_valid_q || s2_load;
  assign accept        = match_valid_i && match_ready_o;

  // Valid-bit next state: clear_all beats clear beats set.
  always_comb begin
    valid_d = valid_q;
    if (set_valid_i) begin
      valid_d[set_index_i] = 1'b1;
    end
    if (clear_valid_i) begin
      valid_d[clear_index_i] = 1'b0;
    end
    if (clear_all_i) begin
      valid_d = '0;
    end
  end

  // Lowest-index priority encode plus population count of the S1 vector.
  always_comb begin
    enc_hit   = 1'b0;
    enc_index = '0;
    enc_count = '0;
    // Scan downwards so the last assignment wins for the lowest set bit.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (s1_vec_q[i]) begin
        enc_hit   = 1'b1;
        enc_index = ADDR_WIDTH'(i);
        enc_count = enc_count + CntW'(1);
      end
    end
  end

  // Pipeline next state for both stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_vec_d   = s1_vec_q;
    s2_valid_d = s2_valid_q;
    s2_hit_d   = s2_hit_q;
    s2_index_d = s2_index_q;
    s2_count_d = s2_count_q;
    s2_multi_d = s2_multi_q;

    if (match_ready_o) begin
      s1_valid_d = match_valid_i;
    end
    // Gate with the pre-update valid vector so same-cycle set/clear is not seen.
    if (accept) begin
      s1_vec_d = match_i & valid_q;
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_hit_d   = enc_hit;
        s2_index_d = enc_index;
        s2_count_d = enc_count;
        s2_multi_d = (enc_count >= CntW'(2));
      end
    end
  end

  // State registers with synchronous reset; reset discards in-flight results.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_vec_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_index_q <= '0;
      s2_count_q <= '0;
      s2_multi_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      s1_valid_q <= s1_valid_d;
      s1_vec_q   <= s1_vec_d;
      s2_valid_q <= s2_valid_d;
      s2_hit_q   <= s2_hit_d;
      s2_index_q <= s2_index_d;
      s2_count_q <= s2_count_d;
      s2_multi_q <= s2_multi_d;
    end
  end

  assign valid_bits_o   = valid_q;
  assign result_valid_o = s2_valid_q;
  assign hit_o          = s2_hit_q;
  assign index_o        = s2_index_q;
  assign hit_count_o    = s2_count_q;
  assign multi_hit_o    = s2_multi_q;

endmodule

// File: tb/tb_cam_match_encoder.sv
// Self-checking bench for cam_match_encoder: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_cam_match_encoder;

  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             match_valid_i;
  logic [DEPTH-1:0] match_i;
  logic             match_ready_o;
  logic             set_valid_i;
  logic [AW-1:0]    set_index_i;
  logic             clear_valid_i;
  logic [AW-1:0]    clear_index_i;
  logic             clear_all_i;
  logic [DEPTH-1:0] valid_bits_o;
  logic             result_valid_o;
  logic             result_ready_i;
  logic             hit_o;
  logic [AW-1:0]    index_o;
  logic [AW:0]      hit_count_o;
  logic             multi_hit_o;

  cam_match_encoder #(
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .match_valid_i (match_valid_i),
    .match_i       (match_i),
    .match_ready_o (match_ready_o),
    .set_valid_i   (set_valid_i),
    .set_index_i   (set_index_i),
    .clear_valid_i (clear_valid_i),
    .clear_index_i (clear_index_i),
    .clear_all_i   (clear_all_i),
    .valid_bits_o  (valid_bits_o),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .hit_o         (hit_o),
    .index_o       (index_o),
    .hit_count_o   (hit_count_o),
    .multi_hit_o   (multi_hit_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  // Reference model: entry-valid set and FIFO of accepted searches.
  typedef struct {
    logic [DEPTH-1:0] gated;
    int               acc;   // edge at which the search was accepted
  } entry_t;

  entry_t           q[$];
  logic [DEPTH-1:0] m_valid = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_lowest(input logic [DEPTH-1:0] g);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (g[i]) return i;
    end
    return 0;
  endfunction

  // Count edges so the model knows how long the head entry has been in flight.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: check DUT state after the last edge, then advance the model for the next one.
  always @(negedge clk) begin
    bit               exp_rv;
    bit               exp_rdy;
    logic [DEPTH-1:0] g;
    logic [DEPTH-1:0] nv;
    int               cnt;
    exp_rv  = 1'b0;
    if (q.size() > 0) exp_rv = (edge_cnt >= q[0].acc + 1);
    exp_rdy = (q.size() < 2) || result_ready_i;
    if (edge_cnt > 0) begin
      check_eq("mon_valid_bits", valid_bits_o, m_valid);
      check_eq("mon_match_ready", match_ready_o, exp_rdy);
      check_eq("mon_result_valid", result_valid_o, exp_rv);
      if (exp_rv) begin
        g   = q[0].gated;
        cnt = $countones(g);
        check_eq("mon_hit", hit_o, (g != '0));
        check_eq("mon_index", index_o, ref_lowest(g));
        check_eq("mon_hit_count", hit_count_o, cnt);
        check_eq("mon_multi_hit", multi_hit_o, (cnt >= 2));
      end
    end
    if (reset_i) begin
      q.delete();
      m_valid = '0;
    end else begin
      if (exp_rv && result_ready_i) void'(q.pop_front());
      if (match_valid_i && exp_rdy) q.push_back('{gated: match_i & m_valid, acc: edge_cnt + 1});
      nv = m_valid;
      if (set_valid_i)   nv[set_index_i]   = 1'b1;
      if (clear_valid_i) nv[clear_index_i] = 1'b0;
      if (clear_all_i)   nv = '0;
      m_valid = nv;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int idx);
    set_valid_i = 1'b1;
    set_index_i = AW'(idx);
    tick();
    set_valid_i = 1'b0;
  endtask

  task automatic search(input logic [DEPTH-1:0] v);
    match_valid_i = 1'b1;
    match_i       = v;
    tick();
    match_valid_i = 1'b0;
    match_i       = '0;
  endtask

  task automatic expect_result(input string tag, input bit hit, input int idx, input int cnt);
    check_eq({tag, "_valid"}, result_valid_o, 1'b1);
    check_eq({tag, "_hit"}, hit_o, hit);
    check_eq({tag, "_index"}, index_o, idx);
    check_eq({tag, "_count"}, hit_count_o, cnt);
    check_eq({tag, "_multi"}, multi_hit_o, (cnt >= 2));
  endtask

  // Search, confirm nothing after one edge, then check the result after two.
  task automatic search_expect(input string tag, input logic [DEPTH-1:0] v,
                               input bit hit, input int idx, input int cnt);
    search(v);
    @(negedge clk);
    check_eq({tag, "_lat1"}, result_valid_o, 1'b0);
    tick();
    @(negedge clk);
    expect_result(tag, hit, idx, cnt);
    tick();
  endtask

  initial begin
    reset_i        = 1'b1;
    match_valid_i  = 1'b0;
    match_i        = '0;
    set_valid_i    = 1'b0;
    set_index_i    = '0;
    clear_valid_i  = 1'b0;
    clear_index_i  = '0;
    clear_all_i    = 1'b0;
    result_ready_i = 1'b1;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check_eq("rst_result_valid", result_valid_o, 1'b0);
    check_eq("rst_valid_bits", valid_bits_o, '0);
    check_eq("rst_hit", hit_o, 1'b0);
    check_eq("rst_index", index_o, 0);
    check_eq("rst_count", hit_count_o, 0);
    check_eq("rst_multi", multi_hit_o, 1'b0);
    tick();
    reset_i = 1'b0;
    @(negedge clk);
    check_eq("rst_ready_after", match_ready_o, 1'b1);
    tick();

    // No valid entries: all-ones search misses
    search_expect("allones_miss", {DEPTH{1'b1}}, 1'b0, 0, 0);

    // Entries 3 and 7, search 0x88
    set_entry(3);
    set_entry(7);
    search_expect("hit_3_7", 32'h88, 1'b1, 3, 2);

    // Same-index set/clear ends cleared
    set_valid_i   = 1'b1;
    set_index_i   = 5;
    clear_valid_i = 1'b1;
    clear_index_i = 5;
    tick();
    set_valid_i   = 1'b0;
    clear_valid_i = 1'b0;
    @(negedge clk);
    check_eq("setclr_same_bit5", valid_bits_o[5], 1'b0);
    tick();
    search_expect("setclr_same_miss", 32'h20, 1'b0, 0, 0);

    // Different-index set/clear both apply: set 9, clear 3 -> {7,9}
    set_valid_i   = 1'b1;
    set_index_i   = 9;
    clear_valid_i = 1'b1;
    clear_index_i = 3;
    tick();
    set_valid_i   = 1'b0;
    clear_valid_i = 1'b0;
    @(negedge clk);
    check_eq("setclr_diff_bits", valid_bits_o, 32'h0000_0280);
    tick();

    // Back-to-back searches under backpressure
    result_ready_i = 1'b0;
    match_valid_i  = 1'b1;
    match_i        = 32'h80;
    tick();
    match_i        = 32'h280;
    tick();
    match_valid_i  = 1'b0;
    match_i        = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("stall_ready_low", match_ready_o, 1'b0);
      expect_result("stall_hold_a", 1'b1, 7, 1);
      tick();
    end
    result_ready_i = 1'b1;
    tick();
    @(negedge clk);
    expect_result("stall_second_b", 1'b1, 7, 2);
    tick();
    @(negedge clk);
    check_eq("stall_drained", result_valid_o, 1'b0);
    tick();

    // clear_all right after an accepted search keeps that hit
    match_valid_i = 1'b1;
    match_i       = 32'h80;
    tick();
    match_valid_i = 1'b0;
    match_i       = '0;
    clear_all_i   = 1'b1;
    tick();
    clear_all_i   = 1'b0;
    @(negedge clk);
    expect_result("clrall_inflight", 1'b1, 7, 1);
    check_eq("clrall_bits", valid_bits_o, '0);
    tick();
    search_expect("clrall_next_miss", 32'h80, 1'b0, 0, 0);

    // Reset with both stages full; inputs during reset are ignored
    set_entry(1);
    set_entry(2);
    result_ready_i = 1'b0;
    match_valid_i  = 1'b1;
    match_i        = 32'h2;
    tick();
    match_i        = 32'h4;
    tick();
    match_i        = {DEPTH{1'b1}};
    set_valid_i    = 1'b1;
    set_index_i    = 4;
    reset_i        = 1'b1;
    tick();
    @(negedge clk);
    check_eq("midrst_result_valid", result_valid_o, 1'b0);
    check_eq("midrst_valid_bits", valid_bits_o, '0);
    tick();
    reset_i        = 1'b0;
    match_valid_i  = 1'b0;
    match_i        = '0;
    set_valid_i    = 1'b0;
    result_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("midrst_no_stale", result_valid_o, 1'b0);
      check_eq("midrst_bits_zero", valid_bits_o, '0);
      tick();
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      reset_i       = ($urandom_range(0, 249) == 0);
      match_valid_i = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: match_i = DEPTH'($urandom);
        1: match_i = DEPTH'($urandom) & DEPTH'($urandom);
        2: begin
          match_i = '0;
          match_i[$urandom_range(0, DEPTH - 1)] = 1'b1;
        end
        3: match_i = {DEPTH{1'b1}};
        default: match_i = '0;
      endcase
      result_ready_i = ($urandom_range(0, 3) != 0);
      set_valid_i    = ($urandom_range(0, 1) == 1);
      set_index_i    = AW'($urandom);
      clear_valid_i  = ($urandom_range(0, 3) == 0);
      clear_index_i  = ($urandom_range(0, 3) == 0) ? set_index_i : AW'($urandom);
      clear_all_i    = ($urandom_range(0, 99) == 0);
      tick();
    end

    // Drain
    reset_i        = 1'b0;
    match_valid_i  = 1'b0;
    set_valid_i    = 1'b0;
    clear_valid_i  = 1'b0;
    clear_all_i    = 1'b0;
    result_ready_i = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check_eq("drain_model_empty", q.size(), 0);
    check_eq("drain_result_valid", result_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_match_encoder.md
CAM_MATCH_ENCODER -- requirements
Module: cam_match_encoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, which is the entry index width.
REQ-002 SHALL have parameter DEPTH, default (1<<ADDR_WIDTH), which is the number of CAM entries and the match-vector width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 match_valid_i  in  1  search match vector from the CAM array is valid.
REQ-007 match_i  in  DEPTH  raw per-entry match lines; bit n means entry n compared equal.
REQ-008 match_ready_o  out  1  the block accepts match_i this cycle.
REQ-009 set_valid_i  in  1  mark entry set_index_i valid (write completion).
REQ-010 set_index_i  in  ADDR_WIDTH  entry to mark valid.
REQ-011 clear_valid_i  in  1  invalidate entry clear_index_i.
REQ-012 clear_index_i  in  ADDR_WIDTH  entry to invalidate.
REQ-013 clear_all_i  in  1  invalidate all entries.
REQ-014 valid_bits_o  out  DEPTH  current entry-valid vector (registered).
REQ-015 result_valid_o  out  1  search result available.
REQ-016 result_ready_i  in  1  consumer accepts the result.
REQ-017 hit_o  out  1  at least one valid entry matched.
REQ-018 index_o  out  ADDR_WIDTH  lowest matching valid entry index.
REQ-019 hit_count_o  out  ADDR_WIDTH+1  number of valid entries that matched.
REQ-020 multi_hit_o  out  1  hit_count_o >= 2.

Function
REQ-021 Accept SHALL occur when match_valid_i && match_ready_o.
REQ-022 Stage 1 (S1) SHALL register on accept: gated = match_i & valid_bits, using the valid_bits register value before same-cycle updates.
REQ-023 Stage 2 (S2) SHALL register from S1: hit, lowest set index, popcount, and multi-hit of the gated vector; S2 drives all result outputs.
REQ-024 S1 SHALL advance to S2 when S2 is empty or result_ready_i=1.
REQ-025 match_ready_o SHALL equal !S1_valid || S1-advance; a combinational path from result_ready_i is permitted.
REQ-026 Latency SHALL be 2 cycles: an accept in cycle N gives result_valid_o=1 in cycle N+2 when not stalled.
REQ-027 Throughput SHALL be one result per cycle with result_ready_i held high.
REQ-028 While result_valid_o=1 and result_ready_i=0, all result outputs SHALL hold stable and no result SHALL be lost or duplicated.
REQ-029 A gated vector of zero SHALL produce hit_o=0, index_o=0, hit_count_o=0, multi_hit_o=0.
REQ-030 Priority SHALL be to the lowest index; an all-ones gated vector gives index_o=0 and hit_count_o=DEPTH.
REQ-031 Valid-bit update priority SHALL be: clear_all_i over clear_valid_i over set_valid_i.
REQ-032 When set and clear target the same index in one cycle, the entry SHALL end cleared.
REQ-033 When set and clear target different indices in one cycle, both updates SHALL apply.
REQ-034 clear_all_i SHALL not flush the pipeline; in-flight results SHALL keep their captured gating.

Reset
REQ-035 On reset_i=1 at a clock edge: valid_bits_o SHALL be 0, S1 and S2 empty, result_valid_o=0, hit_o=0, index_o=0, hit_count_o=0, multi_hit_o=0.
REQ-036 Reset mid-operation SHALL discard in-flight results; no result from before reset SHALL appear afterwards.
REQ-037 match_ready_o SHALL be 1 in the first cycle after reset deasserts.
REQ-038 Inputs SHALL be ignored while reset_i=1.

Verification
REQ-039 Bench SHALL cover: set entries 3,7; search match_i=0x88 with ready=1 -> 2 cycles later hit_o=1, index_o=3, hit_count_o=2, multi_hit_o=1.
REQ-040 Bench SHALL cover: no valid bits; search match_i=0xFFFFFFFF -> hit_o=0, index_o=0, hit_count_o=0.
REQ-041 Bench SHALL cover: set and clear of entry 5 in the same cycle -> valid_bits_o[5]=0; then search 0x20 -> hit_o=0.
REQ-042 Bench SHALL cover: back-to-back searches with result_ready_i=0 for 3 cycles -> match_ready_o=0 after 2 accepts, outputs stable, both results delivered in order once ready.
REQ-043 Bench SHALL cover: search accepted, then clear_all_i next cycle -> that result still reports the hit; the following search misses.
REQ-044 Bench SHALL cover: reset asserted with S1 and S2 full -> result_valid_o=0 and valid_bits_o=0 the next cycle, with no stale result after release.
